// File: rtl/dmi_host.sv
// DMI host initiator: turns single local commands into DMI request/response
// transactions toward the debug module. One transaction is outstanding at a
// time. BUSY answers are retried automatically, and a stuck DM is aborted
// after a cycle budget and resynchronised with a one-cycle DMI reset.

package dm_pkg;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    localparam logic [1:0] DTM_NOP   = 2'd0;
    localparam logic [1:0] DTM_READ  = 2'd1;
    localparam logic [1:0] DTM_WRITE = 2'd2;

    localparam logic [1:0] DMI_RESP_SUCCESS  = 2'd0;
    localparam logic [1:0] DMI_RESP_RESERVED = 2'd1;
    localparam logic [1:0] DMI_RESP_FAILED   = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY     = 2'd3;

endpackage

module dmi_host #(
    parameter int TimeoutCycles = 1024,
    parameter int MaxRetries    = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [6:0]          cmd_addr_i,
    input  logic [31:0]         cmd_wdata_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_rdata_o,
    output logic [1:0]          rsp_err_o,
    input  logic                dmi_clear_i,
    output logic                dmi_rst_no,
    output dm_pkg::dmi_req_t    dmi_req_o,
    output logic                dmi_req_valid_o,
    input  logic                dmi_req_ready_i,
    input  dm_pkg::dmi_resp_t   dmi_resp_i,
    input  logic                dmi_resp_valid_i,
    output logic                dmi_resp_ready_o
);

    localparam int TW = $clog2(TimeoutCycles + 1);
    localparam int RW = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;

    // Last budget cycle and the saturation value of the timer.
    localparam logic [TW-1:0] TMO_LAST  = TW'(TimeoutCycles - 1);
    localparam logic [TW-1:0] TMO_SAT   = TW'(TimeoutCycles);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MaxRetries);
    localparam logic [RW-1:0] RETRY_ONE = RW'(1);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_DM      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t        state_r;
    logic [TW-1:0] timer_r;
    logic [RW-1:0] retry_r;

    logic cmd_fire_s;
    logic req_fire_s;
    logic resp_fire_s;
    logic tmo_s;

    // Saturating increment: the timer may pass the last budget cycle only
    // when a handshake lands exactly on it, and must never wrap back to 0.
    function automatic logic [TW-1:0] timer_inc(input logic [TW-1:0] t);
        logic [TW-1:0] n;
        if (t >= TMO_SAT) begin
            n = t;
        end else begin
            n = t + TIMER_ONE;
        end
        return n;
    endfunction

    assign cmd_fire_s  = cmd_valid_i & cmd_ready_o;
    assign req_fire_s  = dmi_req_valid_o & dmi_req_ready_i;
    assign resp_fire_s = dmi_resp_ready_o & dmi_resp_valid_i;
    assign tmo_s       = (timer_r >= TMO_LAST);

    // Transaction FSM: command capture, DMI handshakes, retry/timeout and response hold
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r          <= ST_IDLE;
            timer_r          <= '0;
            retry_r          <= '0;
            cmd_ready_o      <= 1'b0;
            rsp_valid_o      <= 1'b0;
            rsp_rdata_o      <= 32'h0000_0000;
            rsp_err_o        <= ERR_OK;
            dmi_rst_no       <= 1'b0;
            dmi_req_o        <= '0;
            dmi_req_valid_o  <= 1'b0;
            dmi_resp_ready_o <= 1'b0;
        end else begin
            // DM leaves reset on the first clock and after every single-cycle pulse.
            dmi_rst_no <= 1'b1;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        // A command beats a simultaneous clear request.
                        dmi_req_o.addr  <= cmd_addr_i;
                        dmi_req_o.op    <= cmd_we_i ? dm_pkg::DTM_WRITE : dm_pkg::DTM_READ;
                        dmi_req_o.data  <= cmd_we_i ? cmd_wdata_i : 32'h0000_0000;
                        retry_r         <= '0;
                        timer_r         <= '0;
                        cmd_ready_o     <= 1'b0;
                        dmi_req_valid_o <= 1'b1;
                        state_r         <= ST_REQ;
                    end else if (dmi_clear_i && cmd_ready_o && dmi_rst_no) begin
                        dmi_rst_no  <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end else begin
                        cmd_ready_o <= 1'b1;
                    end
                end

                ST_REQ: begin
                    timer_r <= timer_inc(timer_r);
                    if (req_fire_s) begin
                        dmi_req_valid_o  <= 1'b0;
                        dmi_resp_ready_o <= 1'b1;
                        state_r          <= ST_WAIT;
                    end else if (tmo_s) begin
                        dmi_req_valid_o <= 1'b0;
                        dmi_rst_no      <= 1'b0;
                        rsp_valid_o     <= 1'b1;
                        rsp_rdata_o     <= 32'h0000_0000;
                        rsp_err_o       <= ERR_TIMEOUT;
                        state_r         <= ST_DONE;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end

                ST_WAIT: begin
                    timer_r <= timer_inc(timer_r);
                    if (resp_fire_s) begin
                        dmi_resp_ready_o <= 1'b0;
                        case (dmi_resp_i.resp)
                            dm_pkg::DMI_RESP_SUCCESS: begin
                                rsp_valid_o <= 1'b1;
                                rsp_rdata_o <= (dmi_req_o.op == dm_pkg::DTM_READ) ?
                                               dmi_resp_i.data : 32'h0000_0000;
                                rsp_err_o   <= ERR_OK;
                                state_r     <= ST_DONE;
                            end
                            dm_pkg::DMI_RESP_BUSY: begin
                                if (retry_r < RETRY_MAX) begin
                                    // Reissue the identical request with a fresh budget.
                                    retry_r         <= retry_r + RETRY_ONE;
                                    timer_r         <= '0;
                                    dmi_req_valid_o <= 1'b1;
                                    state_r         <= ST_REQ;
                                end else begin
                                    rsp_valid_o <= 1'b1;
                                    rsp_rdata_o <= 32'h0000_0000;
                                    rsp_err_o   <= ERR_DM;
                                    state_r     <= ST_DONE;
                                end
                            end
                            default: begin
                                // FAILED and the reserved code are both DM errors.
                                rsp_valid_o <= 1'b1;
                                rsp_rdata_o <= 32'h0000_0000;
                                rsp_err_o   <= ERR_DM;
                                state_r     <= ST_DONE;
                            end
                        endcase
                    end else if (tmo_s) begin
                        dmi_resp_ready_o <= 1'b0;
                        dmi_rst_no       <= 1'b0;
                        rsp_valid_o      <= 1'b1;
                        rsp_rdata_o      <= 32'h0000_0000;
                        rsp_err_o        <= ERR_TIMEOUT;
                        state_r          <= ST_DONE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end

                ST_DONE: begin
                    if (rsp_ready_i) begin
                        // Ready rises only after the consume cycle, spacing commands apart.
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= 32'h0000_0000;
                        rsp_err_o   <= ERR_OK;
                        cmd_ready_o <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end

                default: begin
                    cmd_ready_o      <= 1'b0;
                    rsp_valid_o      <= 1'b0;
                    dmi_req_valid_o  <= 1'b0;
                    dmi_resp_ready_o <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmi_host.sv
// Self-checking bench for dmi_host: a scripted DM responder, a transaction-level
// outcome model and one per-cycle compare process.
module tb_dmi_host;

    localparam int TMO  = 16;
    localparam int MAXR = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              cmd_valid_i = 1'b0;
    logic              cmd_ready_o;
    logic              cmd_we_i = 1'b0;
    logic [6:0]        cmd_addr_i = 7'h00;
    logic [31:0]       cmd_wdata_i = 32'h0;
    logic              rsp_valid_o;
    logic              rsp_ready_i = 1'b0;
    logic [31:0]       rsp_rdata_o;
    logic [1:0]        rsp_err_o;
    logic              dmi_clear_i = 1'b0;
    logic              dmi_rst_no;
    dm_pkg::dmi_req_t  dmi_req_o;
    logic              dmi_req_valid_o;
    logic              dmi_req_ready_i = 1'b0;
    dm_pkg::dmi_resp_t dmi_resp_i = '0;
    logic              dmi_resp_valid_i = 1'b0;
    logic              dmi_resp_ready_o;

    dmi_host #(.TimeoutCycles(TMO), .MaxRetries(MAXR)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .dmi_clear_i(dmi_clear_i), .dmi_rst_no(dmi_rst_no),
        .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // DM script: request stall cycles, response delay cycles, ordered answers.
    int          cfg_req_stall = 0;
    int          cfg_resp_delay = 0;
    int          cfg_n = 0;
    int          cfg_gen = 0;
    logic [1:0]  cfg_code [8];
    logic [31:0] cfg_data [8];

    // Expectations for the transaction in flight.
    logic [40:0] exp_req = '0;
    logic [31:0] exp_rdata = '0;
    logic [1:0]  exp_err = '0;
    logic        txn_active = 1'b0;

    // Monitor counters.
    int hs_cnt = 0;
    int rst_lo_cnt = 0;
    int req_valid_cyc = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_cfg(input int stall, input int delay);
        cfg_req_stall  = stall;
        cfg_resp_delay = delay;
        cfg_n          = 0;
        cfg_gen++;
    endtask

    task automatic push(input logic [1:0] code, input logic [31:0] data);
        cfg_code[cfg_n] = code;
        cfg_data[cfg_n] = data;
        cfg_n++;
    endtask

    // Outcome model: each attempt needs stall+1 REQ cycles and delay+1 WAIT
    // cycles, all inside a budget of TMO cycles that restarts per attempt.
    // A request accepted on the very last budget cycle still gets one WAIT cycle.
    function automatic void predict(input logic we, output logic [31:0] rd, output logic [1:0] er,
                                    output int hs, output int lat);
        rd = '0; er = 2'd0; hs = 0; lat = 1;
        for (int a = 0; a <= MAXR; a++) begin
            if (cfg_req_stall + 1 > TMO) begin
                er = 2'd2; lat += TMO; return;
            end
            hs++;
            if (a >= cfg_n || (cfg_req_stall + cfg_resp_delay + 2 > TMO &&
                               !(cfg_req_stall + 1 == TMO && cfg_resp_delay == 0))) begin
                er = 2'd2; lat += TMO; return;
            end
            lat += cfg_req_stall + cfg_resp_delay + 2;
            if (cfg_code[a] == 2'd0) begin
                rd = we ? 32'h0 : cfg_data[a]; return;
            end
            if (!(cfg_code[a] == 2'd3 && a < MAXR)) begin
                er = 2'd1; return;
            end
        end
    endfunction

    // Scripted DM responder: decide handshakes at negedge, drive just after posedge.
    initial begin
        int stall_cnt = 0;
        int wait_cnt = 0;
        int idx = 0;
        int gen = 0;
        forever begin
            @(negedge clk_i);
            if (gen != cfg_gen) begin
                gen = cfg_gen; idx = 0;
            end
            if (dmi_resp_ready_o && dmi_resp_valid_i) idx++;
            @(posedge clk_i); #1;
            if (dmi_req_valid_o) begin
                if (stall_cnt < cfg_req_stall) begin
                    dmi_req_ready_i = 1'b0; stall_cnt++;
                end else begin
                    dmi_req_ready_i = 1'b1;
                end
            end else begin
                dmi_req_ready_i = 1'b0; stall_cnt = 0;
            end
            if (dmi_resp_ready_o && idx < cfg_n) begin
                if (wait_cnt < cfg_resp_delay) begin
                    dmi_resp_valid_i = 1'b0; wait_cnt++;
                end else begin
                    dmi_resp_valid_i = 1'b1;
                    dmi_resp_i.data  = cfg_data[idx];
                    dmi_resp_i.resp  = cfg_code[idx];
                end
            end else begin
                dmi_resp_valid_i = 1'b0; wait_cnt = 0;
            end
        end
    end

    // Per-cycle compare against the current expectations.
    logic prev_acc = 1'b0;
    logic prev_resp_hs = 1'b0;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (dmi_req_valid_o) check("dmi_req", 64'(dmi_req_o), 64'(exp_req));
            if (rsp_valid_o) begin
                check("rsp_expected", 64'(txn_active), 64'd1);
                check("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_rdata));
                check("rsp_err", 64'(rsp_err_o), 64'(exp_err));
            end
            if (prev_acc) check("accept_to_req", 64'(dmi_req_valid_o), 64'd1);
            if (prev_resp_hs) check("resp_to_next", 64'(rsp_valid_o | dmi_req_valid_o), 64'd1);
            if (!dmi_rst_no) rst_lo_cnt++;
            if (dmi_req_valid_o) req_valid_cyc++;
            if (dmi_req_valid_o && dmi_req_ready_i) hs_cnt++;
            prev_acc     = cmd_valid_i && cmd_ready_o;
            prev_resp_hs = dmi_resp_valid_i && dmi_resp_ready_o;
        end else begin
            prev_acc = 1'b0; prev_resp_hs = 1'b0;
        end
    end

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!cmd_ready_o && n < 20) begin
            @(posedge clk_i); #1; n++;
        end
        check({nm, "_cmd_ready"}, 64'(cmd_ready_o), 64'd1);
    endtask

    // One full command: issue, wait for the result, hold it, consume it.
    task automatic run_txn(input string nm, input logic we, input logic [6:0] addr,
                           input logic [31:0] wdata, input logic clr,
                           output int hs_d, output int lat, output int rv_d, output int lo_d,
                           output logic [31:0] rd, output logic [1:0] er);
        logic [31:0] prd; logic [1:0] per; int phs, plat;
        int hs0, lo0, rv0;
        predict(we, prd, per, phs, plat);
        exp_req   = {addr, (we ? 2'd2 : 2'd1), (we ? wdata : 32'h0)};
        exp_rdata = prd;
        exp_err   = per;
        wait_ready(nm);
        hs0 = hs_cnt; lo0 = rst_lo_cnt; rv0 = req_valid_cyc;
        txn_active  = 1'b1;
        cmd_valid_i = 1'b1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wdata; dmi_clear_i = clr;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0; dmi_clear_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 200) begin
            @(posedge clk_i); #1; lat++;
        end
        rd = rsp_rdata_o; er = rsp_err_o;
        check({nm, "_latency"}, 64'(lat), 64'(plat));
        repeat (2) begin @(posedge clk_i); #1; end
        rsp_ready_i = 1'b1;
        check({nm, "_no_cmd_in_consume"}, 64'(cmd_ready_o), 64'd0);
        @(posedge clk_i); #1;
        rsp_ready_i = 1'b0;
        check({nm, "_rsp_dropped"}, 64'(rsp_valid_o), 64'd0);
        txn_active = 1'b0;
        hs_d = hs_cnt - hs0; lo_d = rst_lo_cnt - lo0; rv_d = req_valid_cyc - rv0;
        check({nm, "_handshakes"}, 64'(hs_d), 64'(phs));
        check({nm, "_rst_pulse"}, 64'(lo_d), 64'((per == 2'd2) ? 1 : 0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, lat, rv, lo;
        logic [31:0] rd;
        logic [1:0] er;

        // Reset state and release behaviour.
        #12;
        check("reset_ctrl", 64'({cmd_ready_o, rsp_valid_o, rsp_err_o, dmi_rst_no,
                                 dmi_req_valid_o, dmi_resp_ready_o}), 64'd0);
        check("reset_rdata", 64'(rsp_rdata_o), 64'd0);
        check("reset_req", 64'(dmi_req_o), 64'd0);
        #11 rst_ni = 1'b1;
        #1 check("rst_no_before_edge", 64'(dmi_rst_no), 64'd0);
        @(posedge clk_i); #1;
        check("rst_no_after_edge", 64'(dmi_rst_no), 64'd1);

        // Read, DM ready at once.
        set_cfg(0, 0); push(2'd0, 32'hDEAD_BEEF);
        run_txn("read", 1'b0, 7'h11, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("read_rdata_lit", 64'(rd), 64'hDEAD_BEEF);
        check("read_err_lit", 64'(er), 64'd0);
        check("read_lat_lit", 64'(lat), 64'd3);

        // Write with 5 cycles of request backpressure.
        set_cfg(5, 0); push(2'd0, 32'h1234_5678);
        run_txn("write_bp", 1'b1, 7'h10, 32'h8000_0001, 1'b0, hs, lat, rv, lo, rd, er);
        check("write_bp_valid_cycles_lit", 64'(rv), 64'd6);
        check("write_bp_rdata_lit", 64'(rd), 64'd0);

        // Three BUSY answers then success.
        set_cfg(0, 0); push(2'd3, 32'h0); push(2'd3, 32'h0); push(2'd3, 32'h0); push(2'd0, 32'h5);
        run_txn("busy3", 1'b0, 7'h04, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("busy3_hs_lit", 64'(hs), 64'd4);
        check("busy3_rdata_lit", 64'(rd), 64'h5);

        // Five BUSY answers exhaust the retries.
        set_cfg(0, 1);
        for (int i = 0; i < 5; i++) push(2'd3, 32'hFFFF_FFFF);
        push(2'd0, 32'h77);
        run_txn("busy5", 1'b0, 7'h04, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("busy5_hs_lit", 64'(hs), 64'd5);
        check("busy5_err_lit", 64'(er), 64'd1);

        // FAILED and reserved answers.
        set_cfg(0, 2); push(2'd2, 32'hAAAA_5555);
        run_txn("failed", 1'b1, 7'h38, 32'h0000_00F0, 1'b0, hs, lat, rv, lo, rd, er);
        set_cfg(1, 0); push(2'd1, 32'hAAAA_5555);
        run_txn("reserved", 1'b0, 7'h7F, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("reserved_rdata_lit", 64'(rd), 64'd0);

        // Timeout with the request never accepted.
        set_cfg(1000, 0); push(2'd0, 32'h1);
        run_txn("tmo_req", 1'b0, 7'h11, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("tmo_req_err_lit", 64'(er), 64'd2);
        check("tmo_req_lat_lit", 64'(lat), 64'd17);
        check("tmo_req_pulse_lit", 64'(lo), 64'd1);

        // Next command completes normally.
        set_cfg(0, 3); push(2'd0, 32'hCAFE_F00D);
        run_txn("after_tmo", 1'b0, 7'h12, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("after_tmo_rdata_lit", 64'(rd), 64'hCAFE_F00D);

        // Response in the exact expiry cycle wins; one cycle later is a timeout.
        set_cfg(0, 14); push(2'd0, 32'h0BAD_CAFE);
        run_txn("edge_ok", 1'b0, 7'h16, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("edge_ok_err_lit", 64'(er), 64'd0);
        check("edge_ok_rdata_lit", 64'(rd), 64'h0BAD_CAFE);
        set_cfg(0, 15); push(2'd0, 32'h0BAD_CAFE);
        run_txn("edge_tmo", 1'b0, 7'h16, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("edge_tmo_err_lit", 64'(er), 64'd2);

        // Retry restarts the budget: two 15-cycle attempts succeed.
        set_cfg(3, 10); push(2'd3, 32'h0); push(2'd0, 32'h0000_0A0A);
        run_txn("retry_budget", 1'b0, 7'h20, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("retry_budget_lat_lit", 64'(lat), 64'd31);

        // Clear alone pulses the DMI reset for one cycle.
        wait_ready("clear");
        lo = rst_lo_cnt;
        dmi_clear_i = 1'b1;
        @(posedge clk_i); #1;
        dmi_clear_i = 1'b0;
        check("clear_low", 64'(dmi_rst_no), 64'd0);
        @(posedge clk_i); #1;
        check("clear_high_again", 64'(dmi_rst_no), 64'd1);
        check("clear_pulse_len", 64'(rst_lo_cnt - lo), 64'd1);

        // Clear together with a command: command wins, no pulse.
        set_cfg(0, 0); push(2'd0, 32'h0);
        run_txn("clear_cmd", 1'b1, 7'h10, 32'h0000_0003, 1'b1, hs, lat, rv, lo, rd, er);
        check("clear_cmd_pulse_lit", 64'(lo), 64'd0);

        // Reset while waiting for the response.
        set_cfg(0, 1000); push(2'd0, 32'h1);
        exp_req = {7'h33, 2'd1, 32'h0};
        exp_rdata = '0; exp_err = '0;
        wait_ready("rst_wait");
        txn_active  = 1'b1;
        cmd_valid_i = 1'b1; cmd_we_i = 1'b0; cmd_addr_i = 7'h33; cmd_wdata_i = 32'h0;
        @(posedge clk_i); #1;
        cmd_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("rst_wait_in_wait", 64'(dmi_resp_ready_o), 64'd1);
        #2 rst_ni = 1'b0;
        txn_active = 1'b0;
        #1;
        check("rst_wait_ctrl", 64'({cmd_ready_o, rsp_valid_o, rsp_err_o, dmi_rst_no,
                                    dmi_req_valid_o, dmi_resp_ready_o}), 64'd0);
        check("rst_wait_req", 64'(dmi_req_o), 64'd0);
        @(posedge clk_i); #4 rst_ni = 1'b1;
        #1 check("rst_wait_rst_no_low", 64'(dmi_rst_no), 64'd0);
        @(posedge clk_i); #1;
        check("rst_wait_rst_no_high", 64'(dmi_rst_no), 64'd1);
        repeat (6) begin @(posedge clk_i); #1; end
        check("rst_wait_no_rsp", 64'(rsp_valid_o), 64'd0);

        // Normal operation after reset.
        set_cfg(2, 2); push(2'd0, 32'h1357_9BDF);
        run_txn("post_reset", 1'b0, 7'h40, 32'h0, 1'b0, hs, lat, rv, lo, rd, er);
        check("post_reset_rdata_lit", 64'(rd), 64'h1357_9BDF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
